lc4_divider_seq: RTL and testbench

- Multi-cycle unsigned integer divider for the LC4 ALU: quotient = dividend / divisor, remainder = dividend % divisor.
- Inverse operation of the carry-lookahead adder datapath. Implemented as restoring shift-subtract; each trial subtraction is an addition of the inverted divisor with carry-in 1, in the same gp/carry-lookahead style as the adder.
- Sits beside the combinational ALU. Uses a valid/ready handshake on input and output so the pipeline can stall on DIV/MOD.

---
 rtl/lc4_divider_seq.sv | 150 +++++++++++++++
 tb/tb_lc4_divider_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_divider_seq.sv
// lc4_divider_seq: multi-cycle restoring unsigned divider for the LC4 ALU, valid/ready on both sides.
// Optional: define LC4_DIV_EARLY_OUT_EN to finish divide-by-zero and dividend<divisor on the accept edge.
module lc4_divider_seq #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t r_state, w_state_nxt;

  // r_dq starts as the dividend and fills with quotient bits from the LSB as dividend bits leave the MSB.
  logic [WIDTH-1:0]          r_dq, r_dvs, r_rem;
  logic [WIDTH-1:0]          r_quotient, r_remainder;
  logic                      r_dbz;
  logic [CW-1:0]             r_cnt;

  logic [WIDTH-1:0]          w_rem_nxt, w_dq_nxt;
  logic [BITS_PER_CYCLE-1:0] w_qbits;
  logic [WIDTH:0]            w_step;
  logic                      w_accept, w_last, w_early;

  // One restoring step: shift in a dividend bit, then trial-subtract as rem' + ~divisor + 1 with g/p carries.
  // The shifted-out remainder MSB is kept, so the trial is WIDTH+1 bits wide.
  // Returns {quotient_bit, new_remainder}.
  function automatic logic [WIDTH:0] sub_step(input logic [WIDTH-1:0] rem,
                                              input logic             nb,
                                              input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   a, bn, g, p;
    logic [WIDTH+1:0] c;
    logic [WIDTH-1:0] diff;
    a    = {rem, nb};
    bn   = ~{1'b0, dvs};
    g    = a & bn;
    p    = a ^ bn;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i <= WIDTH; i++) c[i+1] = g[i] | (p[i] & c[i]);
    for (int i = 0; i < WIDTH; i++) diff[i] = p[i] ^ c[i];
    // Carry out of the top bit means no borrow: the trial fits and the quotient bit is 1.
    if (c[WIDTH+1]) return {1'b1, diff};
    else            return {1'b0, a[WIDTH-1:0]};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_rem_nxt = r_rem;
    w_qbits   = '0;
    w_step    = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      w_step                         = sub_step(w_rem_nxt, r_dq[WIDTH-1-j], r_dvs);
      w_qbits[BITS_PER_CYCLE-1-j]    = w_step[WIDTH];
      w_rem_nxt                      = w_step[WIDTH-1:0];
    end
    w_dq_nxt = (r_dq << BITS_PER_CYCLE) | WIDTH'(w_qbits);
  end

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(1));

`ifdef LC4_DIV_EARLY_OUT_EN
  assign w_early = (divisor == '0) || (dividend < divisor);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_early ? DONE : BUSY;
      BUSY:    if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Every datapath register is reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq        <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dq  <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_cnt <= CW'(STEPS);
            if (w_early) begin
              r_quotient  <= '0;
              r_remainder <= (divisor == '0) ? '0 : dividend;
              r_dbz       <= (divisor == '0);
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_nxt;
          r_dq  <= w_dq_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            if (r_dvs == '0) begin
              r_quotient  <= '0;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
            end else begin
              r_quotient  <= w_dq_nxt;
              r_remainder <= w_rem_nxt;
              r_dbz       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Self-checking bench for lc4_divider_seq: one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=4 instance,
// directed corner cases plus random operands checked against an arithmetic reference model.
module tb_lc4_divider_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend [2];
  logic [W-1:0] divisor  [2];
  logic [W-1:0] quotient [2];
  logic [W-1:0] remainder[2];

  always #5 clk = ~clk;

  lc4_divider_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dividend[0]), .divisor(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]), .div_by_zero(div_by_zero[0])
  );

  lc4_divider_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dividend[1]), .divisor(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]), .div_by_zero(div_by_zero[1])
  );

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [1:0]   pend;
  logic [W-1:0] exp_q[2], exp_r[2], obs_q[2], obs_r[2];
  logic         exp_dbz[2], obs_dbz[2];
  int           exp_lat[2], obs_lat[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic int steps(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  // Reference: plain arithmetic, LC4 zero-divisor convention, latency from the handshake rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output int lat);
    logic early;
    if (b == 0) begin q = '0; r = '0; dbz = 1'b1; end
    else begin q = a / b; r = a % b; dbz = 1'b0; end
`ifdef LC4_DIV_EARLY_OUT_EN
    early = (b == 0) || (a < b);
`else
    early = 1'b0;
`endif
    lat = early ? 1 : steps(k) + 1;
  endtask

  // Whenever a result is presented it must belong to an accepted operation and match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) begin
          check($sformatf("valid_has_accept%0d", k), 32'(pend[k]), 32'd1);
          if (pend[k]) begin
            check($sformatf("quotient%0d", k),    32'(quotient[k]),    32'(exp_q[k]));
            check($sformatf("remainder%0d", k),   32'(remainder[k]),   32'(exp_r[k]));
            check($sformatf("div_by_zero%0d", k), 32'(div_by_zero[k]), 32'(exp_dbz[k]));
          end
        end
      end
    end
  end

  task automatic accept(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    in_valid[k] = 1'b1;
    dividend[k] = a;
    divisor[k]  = b;
    while (!in_ready[k] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[k]) check($sformatf("accept_timeout%0d", k), 32'(in_ready[k]), 32'd1);
    @(posedge clk);
    model(a, b, k, exp_q[k], exp_r[k], exp_dbz[k], exp_lat[k]);
    pend[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    dividend[k] = 16'($urandom);
    divisor[k]  = 16'($urandom);
  endtask

  // Called on the first negedge after the accept edge; that cycle counts as latency 1.
  task automatic complete(input int k, input int stall);
    int lat = 1;
    while (!out_valid[k] && lat < 60) begin
      check($sformatf("busy_in_ready%0d", k), 32'(in_ready[k]), 32'd0);
      dividend[k] = 16'($urandom);
      divisor[k]  = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency%0d", k), 32'(lat), 32'(exp_lat[k]));
    obs_lat[k] = lat;
    obs_q[k]   = quotient[k];
    obs_r[k]   = remainder[k];
    obs_dbz[k] = div_by_zero[k];
    for (int s = 0; s < stall; s++) begin
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b1;
      dividend[k]  = 16'($urandom);
      divisor[k]   = 16'($urandom);
      @(negedge clk);
      check($sformatf("stall_in_ready%0d", k),  32'(in_ready[k]),  32'd0);
      check($sformatf("stall_out_valid%0d", k), 32'(out_valid[k]), 32'd1);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk);
    pend[k] = 1'b0;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check($sformatf("post_out_valid%0d", k), 32'(out_valid[k]), 32'd0);
    check($sformatf("post_in_ready%0d", k),  32'(in_ready[k]),  32'd1);
  endtask

  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    accept(k, a, b);
    complete(k, stall);
  endtask

  task automatic expect_result(input string name, input int k, input int q, input int r,
                               input int dbz, input int lat);
    check({name, "_q"},   32'(obs_q[k]),   32'(q));
    check({name, "_r"},   32'(obs_r[k]),   32'(r));
    check({name, "_dbz"}, 32'(obs_dbz[k]), 32'(dbz));
    check({name, "_lat"}, 32'(obs_lat[k]), 32'(lat));
  endtask

  task automatic check_reset_state(input string name);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_out_valid%0d", name, k), 32'(out_valid[k]),   32'd0);
      check($sformatf("%s_in_ready%0d", name, k),  32'(in_ready[k]),    32'd1);
      check($sformatf("%s_quotient%0d", name, k),  32'(quotient[k]),    32'd0);
      check($sformatf("%s_remainder%0d", name, k), 32'(remainder[k]),   32'd0);
      check($sformatf("%s_dbz%0d", name, k),       32'(div_by_zero[k]), 32'd0);
    end
  endtask

  task automatic rand_ops(output logic [W-1:0] a, output logic [W-1:0] b);
    case ($urandom_range(0, 5))
      0:       begin a = 16'($urandom); b = '0; end
      1:       begin a = 16'($urandom); b = 16'($urandom_range(1, 15)); end
      2:       begin a = 16'($urandom) & 16'h7FFF; b = 16'($urandom) | 16'h8000; end
      3:       begin a = 16'($urandom); b = a; end
      default: begin a = 16'($urandom); b = 16'($urandom); end
    endcase
  endtask

  localparam int EARLY_LAT =
`ifdef LC4_DIV_EARLY_OUT_EN
    1;
`else
    17;
`endif

  initial begin
    logic [W-1:0] a, b;
    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    pend      = '0;
    for (int k = 0; k < 2; k++) begin
      dividend[k] = '0;
      divisor[k]  = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 16'h0064, 16'h0007, 0);
    expect_result("basic", 0, 'h000E, 'h0002, 0, 17);
    run_op(0, 16'hFFFF, 16'h0001, 0);
    expect_result("max_div1", 0, 'hFFFF, 'h0000, 0, 17);
    run_op(0, 16'hFFFF, 16'hFFFF, 0);
    expect_result("max_same", 0, 'h0001, 'h0000, 0, 17);
    run_op(0, 16'h1234, 16'h0000, 0);
    expect_result("dbz", 0, 0, 0, 1, EARLY_LAT);
    run_op(0, 16'h0003, 16'h0010, 0);
    expect_result("small", 0, 0, 3, 0, EARLY_LAT);
    run_op(0, 16'h00FF, 16'h0010, 5);
    expect_result("stall", 0, 'h000F, 'h000F, 0, 17);

    // Abort mid-operation: reset lands between edges during the eighth BUSY cycle.
    accept(0, 16'h1234, 16'h0056);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("abort");
    pend[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 16'h0009, 16'h0002, 0);
    expect_result("after_abort", 0, 4, 1, 0, 17);

    run_op(1, 16'h0064, 16'h0007, 0);
    expect_result("basic4", 1, 'h000E, 'h0002, 0, 5);
    run_op(1, 16'hFFFF, 16'h0001, 0);
    expect_result("max4", 1, 'hFFFF, 'h0000, 0, 5);

    for (int i = 0; i < 150; i++) begin
      rand_ops(a, b);
      run_op(0, a, b, $urandom_range(0, 2));
    end
    for (int i = 0; i < 1000; i++) begin
      rand_ops(a, b);
      run_op(1, a, b, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
